// File: rtl/exception_arbiter.sv
// Memory-stage exception arbiter: synchronises interrupts, prioritises causes and holds the
// encoded cause for CP0 until acknowledged. Define EXC_TLB_EN to let TLB causes participate.
module exception_arbiter #(
  parameter int INT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TLB_W       = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mem_valid,
  input  logic               stall,
  input  logic [7:0]         except,
  input  logic [TLB_W-1:0]   tlb_except,
  input  logic               trap,
  input  logic               cpu,
  input  logic               adel,
  input  logic               ades,
  input  logic [INT_W-3:0]   hw_int,
  input  logic [31:0]        cp0_status,
  input  logic [31:0]        cp0_cause,
  input  logic               cp0_ack,
  output logic [31:0]        excepttype,
  output logic               except_valid,
  output logic               flush,
  output logic               busy,
  output logic [INT_W-3:0]   int_sync
);

  localparam int HW_W = INT_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   excepttype_q, excepttype_d;
  logic          except_valid_q, except_valid_d;
  logic          flush_q, flush_d;
  logic          busy_q, busy_d;
  logic [HW_W-1:0] sync_q [SYNC_STAGES];
  logic [HW_W-1:0] sync_d [SYNC_STAGES];
  logic [4:0]    tlb_s;
  logic          int_req_s;
  logic [7:0]    code_s;
  logic          unused_s;

`ifdef EXC_TLB_EN
  assign tlb_s    = tlb_except[4:0];
  assign unused_s = &{1'b0, except[1:0], cp0_status[31:8+INT_W], cp0_status[7:3],
                      cp0_cause[31:10], cp0_cause[7:0]};
`else
  assign tlb_s    = 5'b00000;
  assign unused_s = &{1'b0, except[1:0], cp0_status[31:8+INT_W], cp0_status[7:3],
                      cp0_cause[31:10], cp0_cause[7:0], tlb_except};
`endif

  // Highest-priority cause wins; TLB bit 4 maps to the lowest TLB code.
  function automatic logic [7:0] cause_code(
    input logic       int_req,
    input logic [7:0] exc,
    input logic [4:0] tlb,
    input logic       trap_i,
    input logic       cpu_i,
    input logic       adel_i,
    input logic       ades_i
  );
    logic [7:0] code;
    if (int_req)              code = 8'h01;
    else if (exc[7] | adel_i) code = 8'h04;
    else if (ades_i)          code = 8'h05;
    else if (trap_i)          code = 8'h0d;
    else if (cpu_i)           code = 8'h0b;
    else if (tlb[4])          code = 8'h10;
    else if (tlb[3])          code = 8'h11;
    else if (tlb[2])          code = 8'h12;
    else if (tlb[1])          code = 8'h13;
    else if (tlb[0])          code = 8'h14;
    else if (exc[6])          code = 8'h08;
    else if (exc[5])          code = 8'h09;
    else if (exc[4])          code = 8'h0e;
    else if (exc[3])          code = 8'h0a;
    else if (exc[2])          code = 8'h0c;
    else                      code = 8'h00;
    return code;
  endfunction

  assign int_sync  = sync_q[SYNC_STAGES-1];
  assign int_req_s = (|({sync_q[SYNC_STAGES-1], cp0_cause[9:8]} & cp0_status[8+INT_W-1:8]))
                     & cp0_status[0] & ~cp0_status[1] & ~cp0_status[2];
  assign code_s    = cause_code(int_req_s, except, tlb_s, trap, cpu, adel, ades);

  // Interrupt synchroniser shift chain.
  always_comb begin
    sync_d[0] = hw_int;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  // Next-state and registered-output logic; cause is frozen while in HOLD.
  always_comb begin
    state_d        = state_q;
    excepttype_d   = excepttype_q;
    except_valid_d = except_valid_q;
    flush_d        = flush_q;
    busy_d         = busy_q;
    case (state_q)
      IDLE: begin
        if (mem_valid && !stall && (code_s != 8'h00)) begin
          state_d        = HOLD;
          excepttype_d   = {24'h000000, code_s};
          except_valid_d = 1'b1;
          flush_d        = 1'b1;
          busy_d         = 1'b1;
        end else begin
          state_d        = IDLE;
          excepttype_d   = 32'h0000_0000;
          except_valid_d = 1'b0;
          flush_d        = 1'b0;
          busy_d         = 1'b0;
        end
      end
      HOLD: begin
        if (cp0_ack) begin
          state_d        = DRAIN;
          excepttype_d   = 32'h0000_0000;
          except_valid_d = 1'b0;
          flush_d        = 1'b1;
          busy_d         = 1'b1;
        end else begin
          state_d        = HOLD;
        end
      end
      DRAIN: begin
        state_d        = IDLE;
        excepttype_d   = 32'h0000_0000;
        except_valid_d = 1'b0;
        flush_d        = 1'b0;
        busy_d         = 1'b0;
      end
      default: begin
        state_d        = IDLE;
        excepttype_d   = 32'h0000_0000;
        except_valid_d = 1'b0;
        flush_d        = 1'b0;
        busy_d         = 1'b0;
      end
    endcase
  end

  // State machine and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      excepttype_q   <= 32'h0000_0000;
      except_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      excepttype_q   <= excepttype_d;
      except_valid_q <= except_valid_d;
      flush_q        <= flush_d;
      busy_q         <= busy_d;
    end
  end

  assign excepttype   = excepttype_q;
  assign except_valid = except_valid_q;
  assign flush        = flush_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_exception_arbiter.sv
// Scoreboard bench for exception_arbiter: directed scenarios plus randomized traffic
// checked against a table-driven priority model.
module tb_exception_arbiter;
  localparam int INT_W = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TLB_W = 5;
  localparam int HW_W = INT_W - 2;
`ifdef EXC_TLB_EN
  localparam bit TLB_EN = 1'b1;
`else
  localparam bit TLB_EN = 1'b0;
`endif

  logic clk, resetn, mem_valid, stall, trap, cpu, adel, ades, cp0_ack;
  logic [7:0] except;
  logic [TLB_W-1:0] tlb_except;
  logic [HW_W-1:0] hw_int, int_sync;
  logic [31:0] cp0_status, cp0_cause, excepttype;
  logic except_valid, flush, busy;

  exception_arbiter #(.INT_W(INT_W), .SYNC_STAGES(SYNC_STAGES), .TLB_W(TLB_W)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .stall(stall), .except(except),
    .tlb_except(tlb_except), .trap(trap), .cpu(cpu), .adel(adel), .ades(ades),
    .hw_int(hw_int), .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_ack(cp0_ack),
    .excepttype(excepttype), .except_valid(except_valid), .flush(flush), .busy(busy),
    .int_sync(int_sync));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] held = 8'h00;
  logic prev_ev = 1'b0;

  // Interrupt lines as seen SYNC_STAGES edges after being driven.
  logic [HW_W-1:0] msync [SYNC_STAGES];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) msync[i] <= '0;
    end else begin
      msync[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) msync[i] <= msync[i-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard when a new cause is presented and checks it stays held.
  always @(negedge clk) begin
    if (resetn) begin
      if (except_valid && !prev_ev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_capture", excepttype, 32'h0);
        end else begin
          held = exp_q.pop_front();
          check("excepttype", excepttype, {24'h0, held});
        end
      end else if (except_valid) begin
        check("hold_stable", excepttype, {24'h0, held});
      end
      check("int_sync", {26'h0, int_sync}, {26'h0, msync[SYNC_STAGES-1]});
    end
    prev_ev = except_valid;
  end

  // Priority table in descending order, first asserted entry wins.
  function automatic logic [7:0] model_code();
    bit c[15];
    logic [7:0] k[15];
    bit int_req;
    int_req = ((({msync[SYNC_STAGES-1], cp0_cause[9:8]} & cp0_status[8+INT_W-1:8]) != '0)
               && cp0_status[0] && !cp0_status[1] && !cp0_status[2]);
    c[0] = int_req;              k[0] = 8'h01;
    c[1] = except[7] || adel;    k[1] = 8'h04;
    c[2] = ades;                 k[2] = 8'h05;
    c[3] = trap;                 k[3] = 8'h0d;
    c[4] = cpu;                  k[4] = 8'h0b;
    for (int i = 0; i < 5; i++) begin
      c[5+i] = TLB_EN && tlb_except[4-i];
      k[5+i] = 8'h10 + 8'(i);
    end
    c[10] = except[6]; k[10] = 8'h08;
    c[11] = except[5]; k[11] = 8'h09;
    c[12] = except[4]; k[12] = 8'h0e;
    c[13] = except[3]; k[13] = 8'h0a;
    c[14] = except[2]; k[14] = 8'h0c;
    for (int i = 0; i < 15; i++) if (c[i]) return k[i];
    return 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    mem_valid = 1'b0; stall = 1'b0; except = 8'h00; tlb_except = '0;
    trap = 1'b0; cpu = 1'b0; adel = 1'b0; ades = 1'b0; cp0_ack = 1'b0;
  endtask

  task automatic rand_m();
    mem_valid  = ($urandom_range(0, 3) != 0);
    stall      = ($urandom_range(0, 3) == 0);
    except     = 8'($urandom & $urandom & $urandom);
    tlb_except = TLB_W'($urandom & $urandom & $urandom);
    trap       = ($urandom_range(0, 7) == 0);
    cpu        = ($urandom_range(0, 7) == 0);
    adel       = ($urandom_range(0, 7) == 0);
    ades       = ($urandom_range(0, 7) == 0);
    cp0_ack    = $urandom_range(0, 1);
  endtask

  task automatic junk();
    rand_m();
    cp0_ack = 1'b0;
  endtask

  // One transaction with inputs already driven; exp is the code the cause should produce.
  task automatic txn(input string tag, input logic [7:0] exp);
    bit cap;
    cap = mem_valid && !stall && (exp != 8'h00);
    if (cap) exp_q.push_back(exp);
    step();
    if (cap) begin
      check({tag, "_valid"}, {31'h0, except_valid}, 32'h1);
      check({tag, "_flush"}, {31'h0, flush}, 32'h1);
      check({tag, "_busy"}, {31'h0, busy}, 32'h1);
      repeat ($urandom_range(0, 3)) begin
        junk();
        step();
        check({tag, "_hold_valid"}, {31'h0, except_valid}, 32'h1);
      end
      junk();
      cp0_ack = 1'b1;
      step();
      check({tag, "_drain_valid"}, {31'h0, except_valid}, 32'h0);
      check({tag, "_drain_flush"}, {31'h0, flush}, 32'h1);
      check({tag, "_drain_busy"}, {31'h0, busy}, 32'h1);
      check({tag, "_drain_type"}, excepttype, 32'h0);
      junk();
      cp0_ack = $urandom_range(0, 1);
      step();
      check({tag, "_idle_flush"}, {31'h0, flush}, 32'h0);
      check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
    end else begin
      check({tag, "_nocap_valid"}, {31'h0, except_valid}, 32'h0);
      check({tag, "_nocap_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_nocap_type"}, excepttype, 32'h0);
    end
    drive_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    resetn = 1'b0;
    drive_idle();
    hw_int = '0; cp0_status = 32'h0; cp0_cause = 32'h0;
    repeat (3) step();
    check("rst_type", excepttype, 32'h0);
    check("rst_valid", {31'h0, except_valid}, 32'h0);
    check("rst_flush", {31'h0, flush}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_int_sync", {26'h0, int_sync}, 32'h0);
    resetn = 1'b1;
    step();

    // Interrupt path latency and two-cycle return to IDLE.
    cp0_status = 32'h0000_0401;
    mem_valid = 1'b1;
    hw_int = 6'b000001;
    exp_q.push_back(8'h01);
    lat = 0;
    while (!except_valid && lat < 10) begin
      step();
      lat++;
    end
    check("int_latency", lat, SYNC_STAGES + 1);
    mem_valid = 1'b0;
    hw_int = '0;
    cp0_ack = 1'b1;
    step();
    check("int_ack_valid", {31'h0, except_valid}, 32'h0);
    check("int_ack_busy", {31'h0, busy}, 32'h1);
    check("int_ack_flush", {31'h0, flush}, 32'h1);
    cp0_ack = 1'b0;
    step();
    check("int_idle_busy", {31'h0, busy}, 32'h0);
    check("int_idle_flush", {31'h0, flush}, 32'h0);
    repeat (3) step();

    // Priority.
    cp0_status = 32'h0;
    mem_valid = 1'b1; adel = 1'b1; trap = 1'b1; except = 8'h40;
    txn("prio_adel", 8'h04);
    mem_valid = 1'b1; trap = 1'b1; except = 8'h40;
    txn("prio_trap", 8'h0d);

    // EXL and ERL masking with a synchronised interrupt pending.
    cp0_status = 32'h0000_0403;
    hw_int = 6'b000001;
    repeat (3) step();
    mem_valid = 1'b1;
    txn("exl_mask", 8'h00);
    mem_valid = 1'b1; except = 8'h40;
    txn("exl_sys", 8'h08);
    cp0_status = 32'h0000_0405;
    mem_valid = 1'b1;
    txn("erl_mask", 8'h00);
    mem_valid = 1'b1; except = 8'h40;
    txn("erl_sys", 8'h08);
    cp0_status = 32'h0;
    hw_int = '0;
    repeat (3) step();

    // Stall blocks capture, release yields the cause.
    repeat (3) begin
      mem_valid = 1'b1; ades = 1'b1; stall = 1'b1;
      txn("stall", 8'h05);
    end
    mem_valid = 1'b1; ades = 1'b1;
    txn("unstall", 8'h05);

    // TLB cause in either build.
    mem_valid = 1'b1; tlb_except = 5'b00100;
    txn("tlb", TLB_EN ? 8'h12 : 8'h00);

    // Asynchronous reset during HOLD.
    mem_valid = 1'b1; ades = 1'b1;
    exp_q.push_back(8'h05);
    step();
    drive_idle();
    step();
    check("pre_rst_valid", {31'h0, except_valid}, 32'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", {31'h0, except_valid}, 32'h0);
    check("arst_flush", {31'h0, flush}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_type", excepttype, 32'h0);
    step();
    resetn = 1'b1;
    step();
    mem_valid = 1'b1; except = 8'h20;
    txn("post_rst", 8'h09);

    // Randomized traffic against the priority model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        cp0_status = {16'h0, 8'($urandom), 5'b00000, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)};
        cp0_cause = {22'h0, 2'($urandom), 8'h00};
      end
      if ($urandom_range(0, 7) == 0) hw_int = HW_W'($urandom);
      rand_m();
      txn("rand", model_code());
    end

    drive_idle();
    repeat (3) step();
    check("queue_empty", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
